// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared constants and FSM state encoding for the divide controller
//   DIV_WIDTH : default operand/result width
//   DIV_ITERS : number of shift-subtract iterations per divide
//   div_state_e : IDLE / BUSY / DONE, 2-bit encoded
package div_ctrl_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: E-stage <-> divide controller bundle
//   master (pipeline) drives : startE, signedE, srcaE, srcbE, cancelE
//   slave (div_ctrl) drives  : stall_divE, readyE, hiE (remainder), loE (quotient)
interface div_ctrl_if #(
    parameter int WIDTH = 32
);

    logic             startE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             cancelE;
    logic             stall_divE;
    logic             readyE;
    logic [WIDTH-1:0] hiE;
    logic [WIDTH-1:0] loE;

    modport master (
        output startE, signedE, srcaE, srcbE, cancelE,
        input  stall_divE, readyE, hiE, loE
    );

    modport slave (
        input  startE, signedE, srcaE, srcbE, cancelE,
        output stall_divE, readyE, hiE, loE
    );

endinterface

// File: rtl/div_ctrl_iter.sv
// div_iter: one combinational radix-2 restoring divide step
//   rem_i : partial remainder (WIDTH+1 bits)
//   quo_i : dividend shift register, quotient bits shift in at the bottom
//   dvs_i : divisor magnitude
//   rem_o / quo_o : values after this step
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;

    // The remainder stays below the divisor, so the top bit of the trial
    // result is a reliable sign: set means the subtract must be undone.
    always_comb begin
        sh    = (rem_i << 1) | {{WIDTH{1'b0}}, quo_i[WIDTH-1]};
        trial = sh - {1'b0, dvs_i};
        rem_o = trial[WIDTH] ? sh : trial;
        quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU sequencer for the E stage with hazard stall and flush cancel
//   clk : pipeline clock
//   rst : synchronous active-low reset
//   bus : div_ctrl_if.slave
//         startE/signedE/srcaE/srcbE start a divide, cancelE aborts it,
//         stall_divE holds the front of the pipe, readyE qualifies hiE/loE for one cycle
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int ITER_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    div_ctrl_if.slave bus
);

    div_state_e       state_q;
    logic [ITER_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             qneg_q;
    logic             rneg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             go;
    logic             last;

    always_comb begin
        go    = state_q == IDLE && bus.startE && !bus.cancelE;
        a_abs = (bus.signedE && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
        b_abs = (bus.signedE && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;
        last  = cnt_q == ITER_W'(WIDTH - 1);
    end

    div_iter #(.WIDTH(WIDTH)) u_iter (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (go) begin
                    cnt_q  <= '0;
                    rem_q  <= '0;
                    quo_q  <= a_abs;
                    dvs_q  <= b_abs;
                    qneg_q <= bus.signedE && (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
                    rneg_q <= bus.signedE && bus.srcaE[WIDTH-1];
                    // Divide by zero bypasses the iterations entirely.
                    if (bus.srcbE == '0) begin
                        state_q <= DONE;
                        hi_q    <= bus.srcaE;
                        lo_q    <= '1;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                BUSY: if (bus.cancelE) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state_q <= DONE;
                        hi_q    <= rneg_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
                        lo_q    <= qneg_q ? -quo_d : quo_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall must be visible in the start cycle itself, so it is decoded from
    // the current state and inputs; a flush or reset drops it immediately.
    assign bus.stall_divE = rst && !bus.cancelE && ((state_q == IDLE && bus.startE) || state_q == BUSY);
    assign bus.readyE     = rst && !bus.cancelE && state_q == DONE;
    assign bus.hiE        = hi_q;
    assign bus.loE        = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with directed divide vectors
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    div_ctrl_if #(.WIDTH(32)) bus ();

    div_ctrl #(.WIDTH(32), .ITER_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every readyE pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst && bus.readyE) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hiE", bus.hiE, e.hi);
                chk("loE", bus.loE, e.lo);
            end
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk);
        #1;
        bus.startE  = 1'b1;
        bus.signedE = s;
        bus.srcaE   = a;
        bus.srcbE   = b;
        bus.cancelE = 1'b0;
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] elo, input logic [31:0] ehi, input int elat);
        int   t0;
        logic bad;
        sb.push_back({ehi, elo});
        start(a, b, s);
        t0  = cyc;
        bad = 1'b0;
        @(negedge clk);
        while (!bus.readyE && (cyc - t0) < 100) begin
            if (bus.stall_divE !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        chk("stall_busy", {31'd0, bad}, 32'd0);
        chk("latency", 32'(cyc - t0), 32'(elat));
        chk("stall_done", {31'd0, bus.stall_divE}, 32'd0);
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        bus.startE  = 1'b0;
        bus.cancelE = 1'b0;
        @(negedge clk);
        chk("idle_stall", {31'd0, bus.stall_divE}, 32'd0);
        chk("idle_ready", {31'd0, bus.readyE}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        bus.startE  = 1'b0;
        bus.signedE = 1'b0;
        bus.srcaE   = '0;
        bus.srcbE   = '0;
        bus.cancelE = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", bus.hiE, 32'd0);
        chk("rst_lo", bus.loE, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_divE}, 32'd0);
        chk("rst_ready", {31'd0, bus.readyE}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, DIV_ITERS + 1);
        go_idle();
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, DIV_ITERS + 1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, DIV_ITERS + 1);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, DIV_ITERS + 1);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, DIV_ITERS + 1);
        go_idle();
        do_div(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1);
        do_div(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1);
        go_idle();

        // Flush in IDLE: no stall, nothing starts.
        @(posedge clk);
        #1;
        bus.startE  = 1'b1;
        bus.srcaE   = 32'd5;
        bus.srcbE   = 32'd1;
        bus.cancelE = 1'b1;
        @(negedge clk);
        chk("cancel_idle_stall", {31'd0, bus.stall_divE}, 32'd0);
        go_idle();

        // Flush in BUSY at cycle 10, then a new divide right away in cycle 11.
        start(32'd50, 32'd5, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        bus.cancelE = 1'b1;
        bus.startE  = 1'b0;
        @(negedge clk);
        chk("cancel_busy_stall", {31'd0, bus.stall_divE}, 32'd0);
        chk("cancel_busy_ready", {31'd0, bus.readyE}, 32'd0);
        do_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, DIV_ITERS + 1);
        go_idle();

        // Back-to-back: second divide enters the cycle after DONE.
        start(32'd0, 32'd0, 1'b0);
        bus.startE = 1'b0;
        t0 = cyc + 1;
        do_div(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, DIV_ITERS + 1);
        do_div(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, DIV_ITERS + 1);
        chk("b2b_total", 32'(cyc - t0), 32'd67);
        go_idle();

        // Reset in cycle 15 of a divide.
        start(32'd50, 32'd5, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.startE = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", {31'd0, bus.stall_divE}, 32'd0);
        chk("rst_mid_ready", {31'd0, bus.readyE}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_hi", bus.hiE, 32'd0);
        chk("rst_mid_lo", bus.loE, 32'd0);
        chk("rst_mid_stall2", {31'd0, bus.stall_divE}, 32'd0);
        chk("rst_mid_ready2", {31'd0, bus.readyE}, 32'd0);
        do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, DIV_ITERS + 1);
        go_idle();

        repeat (40) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle divide controller for the E stage of the 5-stage MIPS pipeline.
- Accepts DIV/DIVU from the E stage and sequences a radix-2 restoring divide over WIDTH iterations.
- Raises a stall request toward the hazard unit while the divide is in progress (the hazard unit ORs this into stallF/stallD/stallE).
- Delivers a one-cycle result for the HI/LO write path and supports cancellation on pipeline flush.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ITER_W, 6, width of the iteration counter; must satisfy 2^ITER_W > WIDTH.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset: one clock, synchronous, active-low.
- startE  in  1  E-stage instruction is DIV/DIVU; held high by the pipeline while stalled.
- signedE  in  1  1 = DIV (signed), 0 = DIVU; sampled with startE.
- srcaE  in  WIDTH  dividend (rs value after forwarding).
- srcbE  in  WIDTH  divisor (rt value after forwarding).
- cancelE  in  1  flush of the E stage (exception/branch); aborts any divide in progress.
- stall_divE  out  1  stall request to the hazard unit.
- readyE  out  1  result valid this cycle; qualifies the HI/LO write.
- hiE  out  WIDTH  remainder.
- loE  out  WIDTH  quotient.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rst=0 at a clock edge):
  - state=IDLE, counter=0, internal registers=0.
  - stall_divE=0, readyE=0, hiE=0, loE=0.
  - Reset takes priority over everything, including a divide in progress.
- Operand capture:
  - Cycle 0 is the cycle with startE=1, state=IDLE and cancelE=0.
  - stall_divE=1 combinationally in cycle 0; no register delay.
  - At the end of cycle 0, capture |srcaE|, |srcbE| (absolute values only when signedE=1), the quotient sign and the remainder sign.
  - Then go to BUSY with counter=0.
- BUSY:
  - One shift-subtract iteration per cycle; counter increments each cycle.
  - stall_divE=1 throughout.
  - After WIDTH iterations (cycles 1..WIDTH), go to DONE.
- DONE (cycle WIDTH+1, i.e. 33 for the default width):
  - readyE=1, stall_divE=0.
  - hiE/loE hold the sign-corrected results: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - The pipeline advances and writes HI/LO this cycle.
  - Next state is IDLE unconditionally; startE, still high from the stalled instruction, is ignored in DONE.
- readyE is asserted for exactly one cycle per completed divide.
- hiE/loE hold their last value until the next DONE. They are only meaningful when readyE=1.
- Divide by zero (srcbE=0 in cycle 0):
  - BUSY is skipped; cycle 1 is DONE.
  - loE = all ones, hiE = srcaE (dividend as given).
  - stall_divE=1 in cycle 0 only.
- Signed overflow (0x80000000 / 0xFFFFFFFF): follows the normal path and yields loE=0x80000000, hiE=0 with no special case.
- Cancel:
  - cancelE=1 in IDLE: startE is ignored and no stall is raised.
  - cancelE=1 in BUSY or DONE: next state is IDLE, readyE=0 in that cycle, and stall_divE is forced to 0 in the same cycle.
  - The aborted result is never presented.
- Back-to-back divides: a second DIV reaches E the cycle after DONE and starts from IDLE. There is a minimum of one readyE-free gap of 0 stall cycles between them, i.e. no overlap.
- startE asserted in BUSY is ignored; the pipeline guarantees this cannot occur.
- Arithmetic:
  - Partial remainder is WIDTH+1 bits.
  - Trial subtract: if the trial result is non-negative, shift in a quotient bit of 1; otherwise restore.

Decomposition:
- Shared package: state encoding (IDLE/BUSY/DONE as 2-bit localparams) and the constant DIV_ITERS = WIDTH.
- Sub-module div_iter:
  - Purely combinational single iteration.
  - Inputs: partial remainder, dividend shift register, divisor.
  - Outputs: next partial remainder and next shift register.
  - The FSM, sign handling and counter stay in div_ctrl.

Test Plan:
- DIVU 100/7: startE=1 held → stall_divE=1 in cycles 0..32; readyE=1 in cycle 33 with loE=14, hiE=2; stall_divE=0 in cycle 33; IDLE in cycle 34.
- DIV -7/2 (0xFFFFFFF9 / 0x2) → cycle 33: loE=0xFFFFFFFD, hiE=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → loE=0x80000000, hiE=0.
- Divide by zero, DIVU 0x1234/0 → stall_divE=1 in cycle 0 only; readyE=1 in cycle 1 with loE=0xFFFFFFFF, hiE=0x1234.
- Cancel: start DIVU 50/5, assert cancelE in cycle 10 → stall_divE=0 in cycle 10; IDLE in cycle 11; no readyE pulse; a subsequent DIVU 9/3 completes normally with loE=3, hiE=0.
- Reset mid-operation: rst=0 at cycle 15 of a divide → next cycle IDLE with all outputs 0 and no readyE; rst released and a new divide runs full 33-cycle latency.
- Back-to-back: DIVU 10/3 then DIVU 20/6 → readyE at cycles 33 and 67; results (3,1) then (3,2); exactly one readyE per divide.
